p1_cc_extract: RTL and testbench
================================

Name: p1_cc_extract

Overview:
- Upstream neighbour of the control block: parses the Protocol-1 host-to-radio byte stream (two 512-byte frames per 1032-byte UDP payload).
- Each frame begins with sync 7F 7F 7F, then C0..C4, then 504 TX sample bytes.
- Presents each C&C word to control as cmd_addr/cmd_data/cmd_rqst/cmd_requires_resp/cmd_ptt and forwards sample bytes downstream.
- Keeps sync-error and link-timeout status.

Parameters:
- FRAME_BYTES, 512, bytes per frame including sync and C&C (3+5+payload).
- SYNC_BYTE, 8'h7F, sync pattern byte.
- TIMEOUT_CYC, 2500000, clk cycles without a good frame before link_lost asserts (1 s at 2.5 MHz).

Ports:
- clk  in  1  system clock (control clock domain).
- rst_n  in  1  synchronous reset, active low.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data valid this cycle; no backpressure.
- in_sop  in  1  first byte of a UDP payload; qualified by in_valid.
- cmd_addr  out  6  C0[6:1] of the last complete C&C.
- cmd_data  out  32  {C1,C2,C3,C4}.
- cmd_ptt  out  1  C0[0].
- cmd_requires_resp  out  1  C0[7].
- cmd_rqst  out  1  one-cycle pulse, new command valid.
- smp_data  out  8  TX sample byte.
- smp_valid  out  1  smp_data valid.
- smp_first  out  1  marks first sample byte of a frame.
- sync_err_cnt  out  8  saturating count of sync failures.
- link_lost  out  1  no good frame within TIMEOUT_CYC.

Behaviour:
- Reset (rst_n=0 at clk edge): state HUNT; cmd_addr=0, cmd_data=0, cmd_ptt=0, cmd_requires_resp=0, cmd_rqst=0, smp_valid=0, smp_first=0, smp_data=0, sync_err_cnt=0, link_lost=1, timeout counter=0, byte counter=0.
- All state advances only on cycles with in_valid=1. in_valid=0 holds the state.
- States: HUNT, S1, S2, C0, C1, C2, C3, C4, PAY.
  - HUNT: byte==SYNC_BYTE -> S1; else stay.
  - S1: byte==SYNC_BYTE -> S2; else sync_err_cnt++ and go to HUNT.
  - S2: same rule as S1, success goes to C0.
  - C0..C4: capture each byte into a shadow register; C4 -> PAY with byte counter=0.
  - PAY: forward each byte as smp_data with smp_valid=1. After FRAME_BYTES-8 bytes (504 at default), next state is S0-check: the following byte must be SYNC_BYTE (-> S1), else sync_err_cnt++ and go to HUNT.
- Command commit: on the clk edge that accepts C4, shadow C0..C3 plus in_data (C4) load into the cmd_* outputs and cmd_rqst=1 for exactly that following cycle. Latency is 1 clk from C4 accepted to cmd_rqst high.
- cmd_* outputs hold until the next commit. Control samples them only on cmd_rqst.
- Sample forwarding: smp_valid/smp_data are registered, 1 clk after the input byte. smp_first=1 only with the first payload byte.
- in_sop=1 with in_valid=1:
  - Forces this byte to be treated as the first sync byte (S1 if it matches, else HUNT), from any state.
  - If the state was C0..C4 or PAY, the partial frame is aborted: sync_err_cnt++, no cmd_rqst, shadow regs discarded.
- sync_err_cnt saturates at 8'hFF; it does not wrap.
- Simultaneous abort and mismatch in one cycle increments sync_err_cnt once only.
- Timeout:
  - Counter clears on every commit (cmd_rqst) and link_lost is cleared on the next cycle.
  - Otherwise the counter increments, saturating at TIMEOUT_CYC.
  - link_lost=1 while counter==TIMEOUT_CYC.
- Reset mid-frame: outputs return to their reset values immediately (next edge); the next frame requires fresh sync.
- Widths: byte counter is 9 bits, timeout counter is 22 bits; both are sized from parameters via clog2.

Test Plan:
- Reset, then a clean frame: 7F 7F 7F, C0=0x13, C1..C4=01 02 03 04, 504 bytes of 0x00..0xF7 -> cmd_rqst one pulse 1 clk after C4; cmd_addr=0x09, cmd_ptt=1, cmd_requires_resp=0, cmd_data=0x01020304; 504 smp_valid with smp_first on byte 0x00; link_lost drops to 0.
- Two back-to-back frames with in_valid toggling 1/0 each cycle -> two cmd_rqst pulses, 1008 sample bytes, sync_err_cnt=0.
- Second sync byte 0x7E -> sync_err_cnt=1, no cmd_rqst; a following good frame is decoded normally.
- in_sop asserted at payload byte 200 with a new good frame -> sync_err_cnt=1; new frame's C&C decoded; smp_first reasserts.
- 300 garbage frames -> sync_err_cnt stops at 255.
- TIMEOUT_CYC=100, one good frame then idle -> link_lost=1 exactly 100 cycles after the cmd_rqst edge; rst_n low mid-payload -> all outputs return to their reset values on the next edge.

Source files
------------

// File: rtl/p1_cc_extract.sv
// Protocol-1 host-to-radio stream parser: finds frame sync, extracts the
// C&C word for the control block, forwards TX samples, tracks link health.
module p1_cc_extract #(
  parameter int          FRAME_BYTES = 512,
  parameter logic [7:0]  SYNC_BYTE   = 8'h7F,
  parameter int          TIMEOUT_CYC = 2500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_sop,
  output logic [5:0]  cmd_addr,
  output logic [31:0] cmd_data,
  output logic        cmd_ptt,
  output logic        cmd_requires_resp,
  output logic        cmd_rqst,
  output logic [7:0]  smp_data,
  output logic        smp_valid,
  output logic        smp_first,
  output logic [7:0]  sync_err_cnt,
  output logic        link_lost
);

  localparam int PAY_BYTES = FRAME_BYTES - 8;
  localparam int BCW = $clog2(PAY_BYTES);
  localparam int TCW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [BCW-1:0] PAY_LAST = BCW'(PAY_BYTES - 1);
  localparam logic [TCW-1:0] TMO_MAX  = TCW'(TIMEOUT_CYC);

  // ST_S0 is the sync check on the byte right after a full payload
  typedef enum logic [3:0] {
    ST_HUNT, ST_S1, ST_S2,
    ST_C0, ST_C1, ST_C2, ST_C3, ST_C4,
    ST_PAY, ST_S0
  } state_e;

  state_e state_q, state_d;

  logic [BCW-1:0] bcnt_q, bcnt_d;
  logic [7:0]     sh0_q, sh0_d;
  logic [7:0]     sh1_q, sh1_d;
  logic [7:0]     sh2_q, sh2_d;
  logic [7:0]     sh3_q, sh3_d;
  logic [5:0]     cmd_addr_q, cmd_addr_d;
  logic [31:0]    cmd_data_q, cmd_data_d;
  logic           cmd_ptt_q, cmd_ptt_d;
  logic           cmd_resp_q, cmd_resp_d;
  logic           cmd_rqst_q, cmd_rqst_d;
  logic [7:0]     smp_data_q, smp_data_d;
  logic           smp_valid_q, smp_valid_d;
  logic           smp_first_q, smp_first_d;
  logic [7:0]     err_q, err_d;
  logic [TCW-1:0] tmo_q, tmo_d;
  logic           lost_q, lost_d;

  logic match;
  logic err_inc;
  logic in_frame;
  logic want_sync;

  assign match = (in_data == SYNC_BYTE);

  assign in_frame = (state_q == ST_C0) || (state_q == ST_C1) ||
                    (state_q == ST_C2) || (state_q == ST_C3) ||
                    (state_q == ST_C4) || (state_q == ST_PAY);

  assign want_sync = (state_q == ST_S1) || (state_q == ST_S2) ||
                     (state_q == ST_S0);

  // Frame parser: next state, shadow capture, commit and sample forward
  always_comb begin
    state_d     = state_q;
    bcnt_d      = bcnt_q;
    sh0_d       = sh0_q;
    sh1_d       = sh1_q;
    sh2_d       = sh2_q;
    sh3_d       = sh3_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_data_d  = cmd_data_q;
    cmd_ptt_d   = cmd_ptt_q;
    cmd_resp_d  = cmd_resp_q;
    cmd_rqst_d  = 1'b0;
    smp_data_d  = smp_data_q;
    smp_valid_d = 1'b0;
    smp_first_d = 1'b0;
    err_inc     = 1'b0;
    if (in_valid) begin
      if (in_sop) begin
        state_d = match ? ST_S1 : ST_HUNT;
        err_inc = in_frame || (want_sync && !match);
      end else begin
        unique case (state_q)
          ST_HUNT: begin
            if (match) state_d = ST_S1;
          end
          ST_S1: begin
            if (match) state_d = ST_S2;
            else begin
              state_d = ST_HUNT;
              err_inc = 1'b1;
            end
          end
          ST_S2: begin
            if (match) state_d = ST_C0;
            else begin
              state_d = ST_HUNT;
              err_inc = 1'b1;
            end
          end
          ST_C0: begin
            sh0_d   = in_data;
            state_d = ST_C1;
          end
          ST_C1: begin
            sh1_d   = in_data;
            state_d = ST_C2;
          end
          ST_C2: begin
            sh2_d   = in_data;
            state_d = ST_C3;
          end
          ST_C3: begin
            sh3_d   = in_data;
            state_d = ST_C4;
          end
          ST_C4: begin
            cmd_addr_d = sh0_q[6:1];
            cmd_ptt_d  = sh0_q[0];
            cmd_resp_d = sh0_q[7];
            cmd_data_d = {sh1_q, sh2_q, sh3_q, in_data};
            cmd_rqst_d = 1'b1;
            bcnt_d     = '0;
            state_d    = ST_PAY;
          end
          ST_PAY: begin
            smp_valid_d = 1'b1;
            smp_data_d  = in_data;
            smp_first_d = (bcnt_q == '0);
            if (bcnt_q == PAY_LAST) state_d = ST_S0;
            else bcnt_d = bcnt_q + BCW'(1);
          end
          ST_S0: begin
            if (match) state_d = ST_S1;
            else begin
              state_d = ST_HUNT;
              err_inc = 1'b1;
            end
          end
          default: state_d = ST_HUNT;
        endcase
      end
    end
  end

  // Status: saturating sync error count and link timeout
  always_comb begin
    err_d = err_q;
    if (err_inc && (err_q != 8'hFF)) err_d = err_q + 8'd1;
    tmo_d  = tmo_q;
    lost_d = lost_q;
    if (cmd_rqst_d) begin
      tmo_d  = '0;
      lost_d = 1'b0;
    end else begin
      if (tmo_q != TMO_MAX) tmo_d = tmo_q + TCW'(1);
      lost_d = lost_q || (tmo_d == TMO_MAX);
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_HUNT;
      bcnt_q      <= '0;
      sh0_q       <= '0;
      sh1_q       <= '0;
      sh2_q       <= '0;
      sh3_q       <= '0;
      cmd_addr_q  <= '0;
      cmd_data_q  <= '0;
      cmd_ptt_q   <= 1'b0;
      cmd_resp_q  <= 1'b0;
      cmd_rqst_q  <= 1'b0;
      smp_data_q  <= '0;
      smp_valid_q <= 1'b0;
      smp_first_q <= 1'b0;
      err_q       <= '0;
      tmo_q       <= '0;
      lost_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      bcnt_q      <= bcnt_d;
      sh0_q       <= sh0_d;
      sh1_q       <= sh1_d;
      sh2_q       <= sh2_d;
      sh3_q       <= sh3_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_data_q  <= cmd_data_d;
      cmd_ptt_q   <= cmd_ptt_d;
      cmd_resp_q  <= cmd_resp_d;
      cmd_rqst_q  <= cmd_rqst_d;
      smp_data_q  <= smp_data_d;
      smp_valid_q <= smp_valid_d;
      smp_first_q <= smp_first_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
      lost_q      <= lost_d;
    end
  end

  assign cmd_addr          = cmd_addr_q;
  assign cmd_data          = cmd_data_q;
  assign cmd_ptt           = cmd_ptt_q;
  assign cmd_requires_resp = cmd_resp_q;
  assign cmd_rqst          = cmd_rqst_q;
  assign smp_data          = smp_data_q;
  assign smp_valid         = smp_valid_q;
  assign smp_first         = smp_first_q;
  assign sync_err_cnt      = err_q;
  assign link_lost         = lost_q;

endmodule

// File: tb/tb_p1_cc_extract.sv
// Directed bench for p1_cc_extract: frame decode, sync errors, abort,
// saturation, link timeout and mid-frame reset.
module tb_p1_cc_extract;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_sop;
  logic [5:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic        cmd_ptt;
  logic        cmd_requires_resp;
  logic        cmd_rqst;
  logic [7:0]  smp_data;
  logic        smp_valid;
  logic        smp_first;
  logic [7:0]  sync_err_cnt;
  logic        link_lost;

  int checks;
  int failures;
  int rqst_cnt;
  int smp_cnt;
  int first_cnt;
  int bad_smp;
  int idx;

  p1_cc_extract #(.TIMEOUT_CYC(100)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_data           (in_data),
    .in_valid          (in_valid),
    .in_sop            (in_sop),
    .cmd_addr          (cmd_addr),
    .cmd_data          (cmd_data),
    .cmd_ptt           (cmd_ptt),
    .cmd_requires_resp (cmd_requires_resp),
    .cmd_rqst          (cmd_rqst),
    .smp_data          (smp_data),
    .smp_valid         (smp_valid),
    .smp_first         (smp_first),
    .sync_err_cnt      (sync_err_cnt),
    .link_lost         (link_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output monitor: pulse/sample counters and payload sequence model
  always @(negedge clk) begin
    if (!rst_n) begin
      rqst_cnt  <= 0;
      smp_cnt   <= 0;
      first_cnt <= 0;
      bad_smp   <= 0;
      idx       <= 0;
    end else begin
      if (cmd_rqst) rqst_cnt <= rqst_cnt + 1;
      if (smp_valid) begin
        smp_cnt <= smp_cnt + 1;
        if (smp_first) begin
          first_cnt <= first_cnt + 1;
          if (smp_data !== 8'h00) bad_smp <= bad_smp + 1;
          idx <= 1;
        end else begin
          if (smp_data !== 8'(idx)) bad_smp <= bad_smp + 1;
          idx <= idx + 1;
        end
      end
    end
  end

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input logic sop,
                      input int gap);
    in_data  = b;
    in_valid = 1'b1;
    in_sop   = sop;
    @(negedge clk);
    in_valid = 1'b0;
    in_sop   = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_hdr(input logic [7:0] c0, input logic [31:0] d,
                          input logic sop, input int gap);
    send(8'h7F, sop, gap);
    send(8'h7F, 1'b0, gap);
    send(8'h7F, 1'b0, gap);
    send(c0, 1'b0, gap);
    send(d[31:24], 1'b0, gap);
    send(d[23:16], 1'b0, gap);
    send(d[15:8], 1'b0, gap);
    send(d[7:0], 1'b0, gap);
  endtask

  task automatic send_pay(input int n, input int gap);
    for (int i = 0; i < n; i++) send(8'(i), 1'b0, gap);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (cmd_addr !== 6'h00 || cmd_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_cmd got addr=%h data=%h exp 00/0", cmd_addr, cmd_data);
    end
    checks++;
    if (cmd_rqst !== 1'b0 || smp_valid !== 1'b0 || smp_first !== 1'b0) begin
      failures++;
      $display("FAIL reset_pulses got rqst=%b sv=%b sf=%b exp 0",
               cmd_rqst, smp_valid, smp_first);
    end
    checks++;
    if (sync_err_cnt !== 8'h00 || link_lost !== 1'b1) begin
      failures++;
      $display("FAIL reset_status got err=%h lost=%b exp 00/1",
               sync_err_cnt, link_lost);
    end
  endtask

  task automatic test_clean_frame();
    do_reset();
    send_hdr(8'h13, 32'h01020304, 1'b0, 0);
    checks++;
    if (cmd_rqst !== 1'b1) begin
      failures++;
      $display("FAIL clean_rqst_lat got %b exp 1", cmd_rqst);
    end
    checks++;
    if (cmd_addr !== 6'h09 || cmd_ptt !== 1'b1 || cmd_requires_resp !== 1'b0) begin
      failures++;
      $display("FAIL clean_c0 got addr=%h ptt=%b resp=%b exp 09/1/0",
               cmd_addr, cmd_ptt, cmd_requires_resp);
    end
    checks++;
    if (cmd_data !== 32'h01020304) begin
      failures++;
      $display("FAIL clean_data got %h exp 01020304", cmd_data);
    end
    checks++;
    if (link_lost !== 1'b0) begin
      failures++;
      $display("FAIL clean_link got %b exp 0", link_lost);
    end
    send(8'h00, 1'b0, 0);
    checks++;
    if (cmd_rqst !== 1'b0 || smp_valid !== 1'b1 || smp_first !== 1'b1) begin
      failures++;
      $display("FAIL clean_first got rqst=%b sv=%b sf=%b exp 0/1/1",
               cmd_rqst, smp_valid, smp_first);
    end
    for (int i = 1; i < 504; i++) send(8'(i), 1'b0, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (rqst_cnt !== 1 || smp_cnt !== 504 || first_cnt !== 1 || bad_smp !== 0) begin
      failures++;
      $display("FAIL clean_counts got rq=%0d smp=%0d first=%0d bad=%0d exp 1/504/1/0",
               rqst_cnt, smp_cnt, first_cnt, bad_smp);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_hdr(8'h13, 32'h01020304, 1'b0, 1);
    send_pay(504, 1);
    send_hdr(8'h04, 32'hAABBCCDD, 1'b0, 1);
    send_pay(504, 1);
    repeat (3) @(negedge clk);
    checks++;
    if (rqst_cnt !== 2 || smp_cnt !== 1008 || first_cnt !== 2 || bad_smp !== 0) begin
      failures++;
      $display("FAIL b2b_counts got rq=%0d smp=%0d first=%0d bad=%0d exp 2/1008/2/0",
               rqst_cnt, smp_cnt, first_cnt, bad_smp);
    end
    checks++;
    if (sync_err_cnt !== 8'h00) begin
      failures++;
      $display("FAIL b2b_err got %h exp 00", sync_err_cnt);
    end
    checks++;
    if (cmd_addr !== 6'h02 || cmd_ptt !== 1'b0 || cmd_data !== 32'hAABBCCDD) begin
      failures++;
      $display("FAIL b2b_cmd got addr=%h ptt=%b data=%h exp 02/0/AABBCCDD",
               cmd_addr, cmd_ptt, cmd_data);
    end
  endtask

  task automatic test_sync_err();
    do_reset();
    send(8'h7F, 1'b0, 0);
    send(8'h7E, 1'b0, 0);
    checks++;
    if (sync_err_cnt !== 8'h01 || rqst_cnt !== 0) begin
      failures++;
      $display("FAIL syncerr_cnt got err=%h rq=%0d exp 01/0", sync_err_cnt, rqst_cnt);
    end
    send_hdr(8'h81, 32'h11223344, 1'b0, 0);
    send_pay(504, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (rqst_cnt !== 1 || smp_cnt !== 504 || sync_err_cnt !== 8'h01) begin
      failures++;
      $display("FAIL syncerr_recover got rq=%0d smp=%0d err=%h exp 1/504/01",
               rqst_cnt, smp_cnt, sync_err_cnt);
    end
    checks++;
    if (cmd_addr !== 6'h00 || cmd_requires_resp !== 1'b1 || cmd_ptt !== 1'b1 ||
        cmd_data !== 32'h11223344) begin
      failures++;
      $display("FAIL syncerr_cmd got addr=%h resp=%b ptt=%b data=%h exp 00/1/1/11223344",
               cmd_addr, cmd_requires_resp, cmd_ptt, cmd_data);
    end
  endtask

  task automatic test_sop_abort();
    do_reset();
    send_hdr(8'h13, 32'h01020304, 1'b0, 0);
    send_pay(200, 0);
    send_hdr(8'h7E, 32'h55667788, 1'b1, 0);
    send_pay(504, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (sync_err_cnt !== 8'h01) begin
      failures++;
      $display("FAIL sop_err got %h exp 01", sync_err_cnt);
    end
    checks++;
    if (rqst_cnt !== 2 || first_cnt !== 2 || smp_cnt !== 704 || bad_smp !== 0) begin
      failures++;
      $display("FAIL sop_counts got rq=%0d first=%0d smp=%0d bad=%0d exp 2/2/704/0",
               rqst_cnt, first_cnt, smp_cnt, bad_smp);
    end
    checks++;
    if (cmd_addr !== 6'h3F || cmd_ptt !== 1'b0 || cmd_data !== 32'h55667788) begin
      failures++;
      $display("FAIL sop_cmd got addr=%h ptt=%b data=%h exp 3F/0/55667788",
               cmd_addr, cmd_ptt, cmd_data);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      send(8'h7F, 1'b0, 0);
      send(8'h00, 1'b0, 0);
    end
    checks++;
    if (sync_err_cnt !== 8'd10) begin
      failures++;
      $display("FAIL sat_mid got %0d exp 10", sync_err_cnt);
    end
    for (int i = 10; i < 300; i++) begin
      send(8'h7F, 1'b0, 0);
      send(8'h00, 1'b0, 0);
    end
    checks++;
    if (sync_err_cnt !== 8'hFF) begin
      failures++;
      $display("FAIL sat_end got %h exp FF", sync_err_cnt);
    end
  endtask

  task automatic test_timeout_reset();
    do_reset();
    send_hdr(8'h13, 32'h01020304, 1'b0, 0);
    checks++;
    if (cmd_rqst !== 1'b1 || link_lost !== 1'b0) begin
      failures++;
      $display("FAIL tmo_start got rqst=%b lost=%b exp 1/0", cmd_rqst, link_lost);
    end
    send_pay(99, 0);
    checks++;
    if (link_lost !== 1'b0) begin
      failures++;
      $display("FAIL tmo_99 got %b exp 0", link_lost);
    end
    send(8'd99, 1'b0, 0);
    checks++;
    if (link_lost !== 1'b1) begin
      failures++;
      $display("FAIL tmo_100 got %b exp 1", link_lost);
    end
    for (int i = 100; i < 150; i++) send(8'(i), 1'b0, 0);
    rst_n = 1'b0;
    send(8'd150, 1'b0, 0);
    checks++;
    if (cmd_addr !== 6'h00 || cmd_data !== 32'h0 || cmd_ptt !== 1'b0 ||
        cmd_requires_resp !== 1'b0 || cmd_rqst !== 1'b0) begin
      failures++;
      $display("FAIL rst_cmd got addr=%h data=%h ptt=%b resp=%b rqst=%b exp 0",
               cmd_addr, cmd_data, cmd_ptt, cmd_requires_resp, cmd_rqst);
    end
    checks++;
    if (smp_valid !== 1'b0 || smp_first !== 1'b0 || smp_data !== 8'h00 ||
        sync_err_cnt !== 8'h00 || link_lost !== 1'b1) begin
      failures++;
      $display("FAIL rst_smp got sv=%b sf=%b sd=%h err=%h lost=%b exp 0/0/00/00/1",
               smp_valid, smp_first, smp_data, sync_err_cnt, link_lost);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h10, 1'b0, 0);
    send(8'h11, 1'b0, 0);
    send(8'h12, 1'b0, 0);
    checks++;
    if (smp_valid !== 1'b0 || sync_err_cnt !== 8'h00) begin
      failures++;
      $display("FAIL rst_resync got sv=%b err=%h exp 0/00", smp_valid, sync_err_cnt);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_data  = 8'h00;
    @(negedge clk);
    test_reset();
    test_clean_frame();
    test_back_to_back();
    test_sync_err();
    test_sop_abort();
    test_saturate();
    test_timeout_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
